// File: rtl/joy_pkg.sv
// Shared types and constants for the controller-port scan scheduler.
// Timing is derived from the clock frequency in 6 us units.
package joy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_HIGH,
    CLK_LOW,
    COMMIT
  } state_t;

  localparam int BTN_W = 12;

  // Button positions in the published word, MSB first: R L X A RT LT DN UP START SELECT Y B
  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DN     = 5;
  localparam int BTN_LT     = 6;
  localparam int BTN_RT     = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  // A real SNES pad always reports this nibble in its last four bits.
  localparam logic [3:0] SNES_ID_NIBBLE = 4'h0;

  typedef struct packed {
    logic [BTN_W-1:0] buttons;
    logic             gametank;
  } pad_result_t;

  function automatic int t6_cycles(input int freq);
    return (freq / 1_000_000) * 6;
  endfunction

  function automatic pad_result_t classify(input logic [15:0] sh);
    pad_result_t r;
    if (sh[15:12] != SNES_ID_NIBBLE) begin
      r.gametank = 1'b1;
      r.buttons  = {4'h0, sh[7:0]};
    end else begin
      r.gametank = 1'b0;
      r.buttons  = sh[11:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/joy_scan_sched_if.sv
// CPU-side read port of the scan scheduler: one-cycle request, registered reply.
interface joy_scan_sched_if;
  import joy_pkg::*;

  logic             rd_req;
  logic             rd_port;
  logic             rd_valid;
  logic [BTN_W-1:0] rd_data;

  modport master (output rd_req, output rd_port, input rd_valid, input rd_data);
  modport slave  (input rd_req, input rd_port, output rd_valid, output rd_data);
endinterface

// File: rtl/joy_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module joy_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: flops are written with <= so every stage samples the pre-edge value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/joy_scan_sched.sv
// Scans both controller ports over a shared latch/clock pair and publishes
// the 12-bit button words atomically at the end of every scan.
module joy_scan_sched
    import joy_pkg::*;
#(
    parameter int FREQ      = 21_500_000,
    parameter int PERIOD_MS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vsync,
    output logic             joy_strb,
    output logic             joy_clk,
    input  logic             joy_data0,
    input  logic             joy_data1,
    output logic [BTN_W-1:0] buttons0,
    output logic [BTN_W-1:0] buttons1,
    output logic [1:0]       pad_type,
    output logic             busy,
    joy_scan_sched_if.slave  rd
);

    localparam int T6        = t6_cycles(FREQ);
    localparam int LATCH_CYC = 2 * T6;
    localparam int PH_W      = $clog2(LATCH_CYC);
    localparam logic [PH_W-1:0] LATCH_LAST = PH_W'(LATCH_CYC - 1);
    localparam logic [PH_W-1:0] HALF_LAST  = PH_W'(T6 - 1);

    localparam int PER_CYC = FREQ / 1000 * PERIOD_MS;
    localparam int PER_W   = $clog2(PER_CYC);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PER_CYC - 1);

    logic vsync_s, data0_s, data1_s;
    logic vsync_d, vs_rise_q;

    joy_sync #(.RST_VAL(1'b0)) u_sync_vsync (.clk(clk), .reset(reset), .d(vsync),     .q(vsync_s));
    joy_sync #(.RST_VAL(1'b1)) u_sync_data0 (.clk(clk), .reset(reset), .d(joy_data0), .q(data0_s));
    joy_sync #(.RST_VAL(1'b1)) u_sync_data1 (.clk(clk), .reset(reset), .d(joy_data1), .q(data1_s));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_d   <= 1'b0;
            vs_rise_q <= 1'b0;
        end else begin
            vsync_d   <= vsync_s;
            vs_rise_q <= vsync_s & ~vsync_d;
        end
    end

    state_t           state;
    logic             pending;
    logic [PH_W-1:0]  ph_cnt;
    logic [3:0]       bit_cnt;
    logic [15:0]      sh0, sh1;
    logic [PER_W-1:0] per_cnt;
    logic             per_hit, trig, scan_start;
    pad_result_t      res0, res1;

    assign per_hit    = (per_cnt == PER_LAST);
    assign trig       = vs_rise_q | per_hit;
    // A trigger seen while idle starts the scan directly rather than via pending.
    assign scan_start = (state == IDLE) && (pending || trig);
    assign res0       = classify(sh0);
    assign res1       = classify(sh1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            per_cnt <= '0;
        end else if (scan_start || per_hit) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pending  <= 1'b1;
            joy_strb <= 1'b0;
            joy_clk  <= 1'b1;
            busy     <= 1'b0;
            ph_cnt   <= '0;
            bit_cnt  <= '0;
            sh0      <= '0;
            sh1      <= '0;
            buttons0 <= '0;
            buttons1 <= '0;
            pad_type <= '0;
        end else begin
            pending <= scan_start ? 1'b0 : (pending | trig);
            case (state)
                IDLE: begin
                    if (scan_start) begin
                        state    <= LATCH;
                        joy_strb <= 1'b1;
                        busy     <= 1'b1;
                        ph_cnt   <= '0;
                        bit_cnt  <= '0;
                    end
                end
                LATCH: begin
                    if (ph_cnt == LATCH_LAST) begin
                        state    <= CLK_HIGH;
                        joy_strb <= 1'b0;
                        ph_cnt   <= '0;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                CLK_HIGH: begin
                    if (ph_cnt == HALF_LAST) begin
                        // Data is active-low; store pressed as 1, first bit ends up in [0].
                        state   <= CLK_LOW;
                        joy_clk <= 1'b0;
                        sh0     <= {~data0_s, sh0[15:1]};
                        sh1     <= {~data1_s, sh1[15:1]};
                        ph_cnt  <= '0;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                CLK_LOW: begin
                    if (ph_cnt == HALF_LAST) begin
                        joy_clk <= 1'b1;
                        ph_cnt  <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        state   <= (bit_cnt == 4'd15) ? COMMIT : CLK_HIGH;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    buttons0 <= res0.buttons;
                    buttons1 <= res1.buttons;
                    pad_type <= {res1.gametank, res0.gametank};
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reads sample the held words, so a request in COMMIT sees the old result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd.rd_valid <= 1'b0;
            rd.rd_data  <= '0;
        end else begin
            rd.rd_valid <= rd.rd_req;
            if (rd.rd_req) begin
                rd.rd_data <= rd.rd_port ? buttons1 : buttons0;
            end
        end
    end

endmodule

// File: tb/tb_joy_scan_sched.sv
// Directed bench for joy_scan_sched at FREQ=1 MHz (T6=6, 205-cycle scans), PERIOD_MS=1.
module tb_joy_scan_sched;
    import joy_pkg::*;

    localparam int FREQ      = 1_000_000;
    localparam int PERIOD_MS = 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             vsync = 1'b0;
    logic             joy_data0 = 1'b1;
    logic             joy_data1 = 1'b1;
    logic             joy_strb, joy_clk, busy;
    logic [BTN_W-1:0] buttons0, buttons1;
    logic [1:0]       pad_type;

    joy_scan_sched_if rd_bus ();

    joy_scan_sched #(.FREQ(FREQ), .PERIOD_MS(PERIOD_MS)) dut (
        .clk      (clk),
        .reset    (reset),
        .vsync    (vsync),
        .joy_strb (joy_strb),
        .joy_clk  (joy_clk),
        .joy_data0(joy_data0),
        .joy_data1(joy_data1),
        .buttons0 (buttons0),
        .buttons1 (buttons1),
        .pad_type (pad_type),
        .busy     (busy),
        .rd       (rd_bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pad model: pressed bits of pat are driven low, one bit per joy_clk pulse.
    logic [15:0] pat0 = '0;
    logic [15:0] pat1 = '0;
    int          bit_idx = 16;
    logic        jclk_q = 1'b1;

    always @(posedge clk) begin
        #1;
        if (joy_strb) bit_idx = 0;
        else if (joy_clk && !jclk_q) bit_idx = bit_idx + 1;
        jclk_q = joy_clk;
        joy_data0 = (bit_idx < 16) ? ~pat0[bit_idx] : 1'b1;
        joy_data1 = (bit_idx < 16) ? ~pat1[bit_idx] : 1'b1;
    end

    // Event monitor: cycle numbers of scan starts and busy edges.
    int   cyc = 0;
    int   n_starts = 0, n_done = 0;
    int   last_start = 0, last_busy_rise = 0, last_busy_fall = 0;
    logic strb_q = 1'b0, busy_q = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (joy_strb && !strb_q) begin n_starts++; last_start = cyc; end
        if (busy && !busy_q) last_busy_rise = cyc;
        if (!busy && busy_q) begin n_done++; last_busy_fall = cyc; end
        strb_q = joy_strb;
        busy_q = busy;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_start(output int s);
        int  n0;
        bit  ok;
        n0 = n_starts;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            tick();
            if (n_starts != n0) ok = 1'b1;
        end
        if (!ok) check("start_timeout", 0, 1);
        s = last_start;
    endtask

    task automatic wait_done();
        int n0;
        bit ok;
        n0 = n_done;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            tick();
            if (n_done != n0) ok = 1'b1;
        end
        if (!ok) check("done_timeout", 0, 1);
    endtask

    task automatic measure_scan(output int s);
        int len, h, l, np, bad;
        wait_start(s);
        len = 0;
        while (joy_strb && len < 100) begin len++; tick(); end
        check("strb_width", len, 12);
        np = 0;
        bad = 0;
        for (int p = 0; p < 16; p++) begin
            h = 0;
            while (joy_clk && h < 100) begin h++; tick(); end
            l = 0;
            while (!joy_clk && l < 100) begin l++; tick(); end
            if (l > 0) np++;
            if (h != 6 || l != 6) bad++;
        end
        check("clk_pulses", np, 16);
        check("clk_bad_widths", bad, 0);
        wait_done();
        check("busy_len", last_busy_fall - last_busy_rise, 205);
    endtask

    initial begin
        #300_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0, s1, s2, s3, s4, s5, f1, v_cyc, rel;
        rd_bus.rd_req  = 1'b0;
        rd_bus.rd_port = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_joy_clk",  joy_clk, 1);
        check("rst_joy_strb", joy_strb, 0);
        check("rst_busy",     busy, 0);
        check("rst_buttons0", buttons0, 0);
        check("rst_buttons1", buttons1, 0);
        check("rst_pad_type", pad_type, 0);
        check("rst_rd_valid", rd_bus.rd_valid, 0);
        check("rst_rd_data",  rd_bus.rd_data, 0);

        // First scan right after release, pads idle
        rel = cyc;
        reset = 1'b0;
        measure_scan(s0);
        check("first_start_latency", s0 - rel, 1);
        check("first_buttons0", buttons0, 0);
        check("first_buttons1", buttons1, 0);

        // SNES pad on port 0 with B and A pressed, port 1 empty
        pat0 = 16'h0101;
        pat1 = 16'h0000;
        measure_scan(s1);
        check("period_gap_first", s1 - s0, 1000);
        check("snes_buttons0", buttons0, (1 << BTN_B) | (1 << BTN_A));
        check("snes_buttons1", buttons1, 0);
        check("snes_pad_type", pad_type, 2'b00);

        // GameTank pad on port 1: low at pulses 1, 4, 13-16
        pat1 = 16'hF009;
        wait_start(s2);
        wait_done();
        check("gt_buttons0", buttons0, 12'h101);
        check("gt_buttons1", buttons1, 12'h009);
        check("gt_pad_type", pad_type, 2'b10);

        // vsync-triggered scan, with two more vsyncs during it
        vsync = 1'b1;
        v_cyc = cyc;
        tick(); tick();
        vsync = 1'b0;
        wait_start(s1);
        check("vsync_latency", s1 - (v_cyc + 1), 3);
        repeat (40) tick();
        vsync = 1'b1; tick(); tick(); vsync = 1'b0;
        repeat (30) tick();
        vsync = 1'b1; tick(); tick(); vsync = 1'b0;
        wait_done();
        f1 = last_busy_fall;
        wait_start(s2);
        check("coalesce_gap", s2 - f1, 1);
        wait_done();
        pat0 = 16'h0800;

        // Only the periodic timer starts the next scan
        wait_start(s3);
        check("period_gap_after_coalesce", s3 - s2, 1000);

        // Read at commit returns old value, next cycle returns new value
        repeat (204) tick();
        check("commit_busy", busy, 1);
        check("rd_valid_idle", rd_bus.rd_valid, 0);
        rd_bus.rd_req  = 1'b1;
        rd_bus.rd_port = 1'b0;
        tick();
        check("rd_commit_valid", rd_bus.rd_valid, 1);
        check("rd_commit_old", rd_bus.rd_data, 12'h101);
        check("commit_buttons0", buttons0, 12'h800);
        tick();
        check("rd_next_valid", rd_bus.rd_valid, 1);
        check("rd_next_new", rd_bus.rd_data, 12'h800);
        rd_bus.rd_req = 1'b0;
        tick();
        check("rd_valid_drop", rd_bus.rd_valid, 0);
        rd_bus.rd_req  = 1'b1;
        rd_bus.rd_port = 1'b1;
        tick();
        rd_bus.rd_req  = 1'b0;
        rd_bus.rd_port = 1'b0;
        check("rd_port1_valid", rd_bus.rd_valid, 1);
        check("rd_port1_data", rd_bus.rd_data, 12'h009);

        // Asynchronous reset during bit 7 (joy_clk low)
        wait_start(s4);
        check("period_gap_read", s4 - s3, 1000);
        repeat (104) tick();
        check("bit7_clk_low", joy_clk, 0);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_joy_clk",  joy_clk, 1);
        check("mid_rst_joy_strb", joy_strb, 0);
        check("mid_rst_busy",     busy, 0);
        check("mid_rst_buttons0", buttons0, 0);
        check("mid_rst_buttons1", buttons1, 0);
        check("mid_rst_pad_type", pad_type, 0);
        tick();
        tick();
        reset = 1'b0;
        measure_scan(s5);
        check("fresh_buttons0", buttons0, 12'h800);
        check("fresh_buttons1", buttons1, 12'h009);
        check("fresh_pad_type", pad_type, 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
